disparity_hole_filler: RTL and testbench

Streaming post-processing stage that consumes the 3205-cycle-aligned pure-disparity stream (`pure_disparity`, `homogeneity`, `pure_valid`, one pixel per clock) and produces a dense disparity map.

- Fills invalid pixels in homogeneous regions:
  - first from the last valid disparity to the left in the same row (bounded run length);
  - otherwise from the already-filled pixel directly above, held in a one-row line memory.
- Sits directly downstream of the disparity delay buffer and feeds the display/output formatter.

---
 rtl/disparity_hole_filler.sv | 166 ++++++++++++++++
 tb/tb_disparity_hole_filler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/disparity_hole_filler.sv
// Hole filler for the pure-disparity stream: left fill with a bounded run, then
// vertical fill from a one-row line memory. Fixed 2-cycle latency, one pixel/clock.
module disparity_hole_filler #(
  parameter int unsigned WIDTH    = 640,
  parameter int unsigned HEIGHT   = 480,
  parameter int unsigned MAX_FILL = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_start,
  input  logic [7:0] i_pure_disparity,
  input  logic       i_homogeneity,
  input  logic       i_pure_valid,
  output logic [7:0] o_disparity,
  output logic       o_filled,
  output logic       o_valid,
  output logic       o_frame_start
);

  localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned RUNW = $clog2(MAX_FILL + 1);

  logic [CW-1:0] col_q, pos_col;
  logic [RW-1:0] row_q, pos_row;
  logic          armed_q;
  logic          act;
  logic          col_last;

  // Stage 1 registers
  logic          s1_act, s1_fs, s1_homog, s1_pv, s1_row_nz;
  logic [7:0]    s1_disp;
  logic [CW-1:0] s1_col;

  // Stage 2 registers (memory read data lands alongside)
  logic          s2_act, s2_fs, s2_homog, s2_pv, s2_row_nz;
  logic [7:0]    s2_disp;
  logic [CW-1:0] s2_col;
  logic [8:0]    mem_rd;

  logic [8:0]    line_mem [WIDTH];

  // Fill state
  logic [7:0]    last_disp;
  logic          has_left;
  logic [RUNW-1:0] run;

  logic            row_start;
  logic            cur_has;
  logic [7:0]      cur_last;
  logic [RUNW-1:0] cur_run, run_inc;
  logic [7:0]      nxt_disp, nxt_last;
  logic            nxt_filled, nxt_valid, nxt_has;
  logic [RUNW-1:0] nxt_run;

  // Position of the current input pixel; a frame start overrides the counters
  always_comb begin
    act      = armed_q | i_frame_start;
    pos_col  = i_frame_start ? '0 : col_q;
    pos_row  = i_frame_start ? '0 : row_q;
    col_last = (pos_col == CW'(WIDTH - 1));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      armed_q <= 1'b0;
    end else if (act) begin
      armed_q <= 1'b1;
      col_q   <= col_last ? '0 : pos_col + CW'(1);
      if (col_last)
        row_q <= (pos_row == RW'(HEIGHT - 1)) ? pos_row : pos_row + RW'(1);
      else
        row_q <= pos_row;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_act <= 1'b0; s1_fs <= 1'b0; s1_homog <= 1'b0; s1_pv <= 1'b0;
      s1_row_nz <= 1'b0; s1_disp <= '0; s1_col <= '0;
      s2_act <= 1'b0; s2_fs <= 1'b0; s2_homog <= 1'b0; s2_pv <= 1'b0;
      s2_row_nz <= 1'b0; s2_disp <= '0; s2_col <= '0;
    end else begin
      s1_act    <= act;
      s1_fs     <= i_frame_start;
      s1_homog  <= i_homogeneity;
      s1_pv     <= i_pure_valid;
      s1_row_nz <= (pos_row != '0);
      s1_disp   <= i_pure_disparity;
      s1_col    <= pos_col;
      s2_act    <= s1_act;
      s2_fs     <= s1_fs;
      s2_homog  <= s1_homog;
      s2_pv     <= s1_pv;
      s2_row_nz <= s1_row_nz;
      s2_disp   <= s1_disp;
      s2_col    <= s1_col;
    end
  end

  // Write lags the next read of the same column by a full row, so no bypass is needed
  always_ff @(posedge i_clk) begin
    mem_rd <= line_mem[s1_col];
    if (s2_act)
      line_mem[s2_col] <= {nxt_valid, nxt_disp};
  end

  always_comb begin
    row_start = (s2_col == '0);
    cur_has   = row_start ? 1'b0 : has_left;
    cur_last  = row_start ? 8'd0 : last_disp;
    cur_run   = row_start ? '0 : run;
    run_inc   = (cur_run == RUNW'(MAX_FILL)) ? cur_run : cur_run + RUNW'(1);

    nxt_disp   = 8'd0;
    nxt_filled = 1'b0;
    nxt_valid  = 1'b0;
    nxt_last   = cur_last;
    nxt_has    = cur_has;
    nxt_run    = run_inc;

    if (s2_pv) begin
      nxt_disp  = s2_disp;
      nxt_valid = 1'b1;
      nxt_last  = s2_disp;
      nxt_has   = 1'b1;
      nxt_run   = '0;
    end else if (s2_homog && cur_has && (cur_run < RUNW'(MAX_FILL))) begin
      nxt_disp   = cur_last;
      nxt_filled = 1'b1;
      nxt_valid  = 1'b1;
    end else if (s2_homog && s2_row_nz && mem_rd[8]) begin
      nxt_disp   = mem_rd[7:0];
      nxt_filled = 1'b1;
      nxt_valid  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_disp     <= '0;
      has_left      <= 1'b0;
      run           <= '0;
      o_disparity   <= '0;
      o_filled      <= 1'b0;
      o_valid       <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (s2_act) begin
      last_disp     <= nxt_last;
      has_left      <= nxt_has;
      run           <= nxt_run;
      o_disparity   <= nxt_disp;
      o_filled      <= nxt_filled;
      o_valid       <= nxt_valid;
      o_frame_start <= s2_fs;
    end else begin
      o_disparity   <= '0;
      o_filled      <= 1'b0;
      o_valid       <= 1'b0;
      o_frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_disparity_hole_filler.sv
// Self-checking bench for disparity_hole_filler: expected outputs are queued at
// drive time and compared two cycles later when the DUT presents them.
module tb_disparity_hole_filler;

  localparam int unsigned WIDTH = 640;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic [7:0] pure_disparity;
  logic       homogeneity;
  logic       pure_valid;
  logic [7:0] disparity;
  logic       filled;
  logic       valid;
  logic       frame_start_out;

  typedef struct packed {
    logic       fs;
    logic       v;
    logic       f;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  disparity_hole_filler #(.WIDTH(WIDTH), .HEIGHT(480), .MAX_FILL(16)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_frame_start    (frame_start),
    .i_pure_disparity (pure_disparity),
    .i_homogeneity    (homogeneity),
    .i_pure_valid     (pure_valid),
    .o_disparity      (disparity),
    .o_filled         (filled),
    .o_valid          (valid),
    .o_frame_start    (frame_start_out)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic fs, input logic [7:0] d, input logic h, input logic v);
    frame_start    = fs;
    pure_disparity = d;
    homogeneity    = h;
    pure_valid     = v;
  endtask

  task automatic push(input logic fs, input logic v, input logic f, input logic [7:0] d);
    exp_t x;
    x.fs = fs; x.v = v; x.f = f; x.d = d;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({frame_start_out, valid, filled, disparity} !== 11'd0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got fs=%b v=%b f=%b d=%0d, expected all 0",
                 i, frame_start_out, valid, filled, disparity);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      push(1'b0, 1'b0, 1'b0, 8'd0);
      @(posedge clk); #1;
      if (sb.size() > 2) begin
        e = sb.pop_front();
        checks++;
        if ({frame_start_out, valid, filled, disparity} !== e) begin
          errors++;
          $display("FAIL unarmed px%0d: got fs=%b v=%b f=%b d=%0d, expected fs=%b v=%b f=%b d=%0d",
                   i, frame_start_out, valid, filled, disparity, e.fs, e.v, e.f, e.d);
        end
      end
    end
  endtask

  task automatic test_pass_through();
    for (int i = 0; i < int'(WIDTH); i++) begin
      drive(i == 0, 8'(i), 1'($urandom), 1'b1);
      push(i == 0, 1'b1, 1'b0, 8'(i));
      @(posedge clk); #1;
      if (sb.size() > 2) begin
        e = sb.pop_front();
        checks++;
        if ({frame_start_out, valid, filled, disparity} !== e) begin
          errors++;
          $display("FAIL pass_through px%0d: got fs=%b v=%b f=%b d=%0d, expected fs=%b v=%b f=%b d=%0d",
                   i, frame_start_out, valid, filled, disparity, e.fs, e.v, e.f, e.d);
        end
      end
    end
  endtask

  task automatic test_left_fill();
    for (int i = 0; i <= 40; i++) begin
      if (i < 10) begin
        drive(i == 0, 8'($urandom), 1'b0, 1'b0);
        push(i == 0, 1'b0, 1'b0, 8'd0);
      end else if (i == 10) begin
        drive(1'b0, 8'd42, 1'b1, 1'b1);
        push(1'b0, 1'b1, 1'b0, 8'd42);
      end else if (i <= 26) begin
        drive(1'b0, 8'($urandom), 1'b1, 1'b0);
        push(1'b0, 1'b1, 1'b1, 8'd42);
      end else begin
        drive(1'b0, 8'($urandom), 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'd0);
      end
      @(posedge clk); #1;
      if (sb.size() > 2) begin
        e = sb.pop_front();
        checks++;
        if ({frame_start_out, valid, filled, disparity} !== e) begin
          errors++;
          $display("FAIL left_fill px%0d: got fs=%b v=%b f=%b d=%0d, expected fs=%b v=%b f=%b d=%0d",
                   i - 2, frame_start_out, valid, filled, disparity, e.fs, e.v, e.f, e.d);
        end
      end
    end
  endtask

  task automatic test_vertical();
    for (int i = 0; i < int'(WIDTH) + 6; i++) begin
      if (i < int'(WIDTH)) begin
        drive(i == 0, 8'd7, 1'($urandom), 1'b1);
        push(i == 0, 1'b1, 1'b0, 8'd7);
      end else begin
        drive(1'b0, 8'($urandom), 1'b1, 1'b0);
        push(1'b0, 1'b1, 1'b1, 8'd7);
      end
      @(posedge clk); #1;
      if (sb.size() > 2) begin
        e = sb.pop_front();
        checks++;
        if ({frame_start_out, valid, filled, disparity} !== e) begin
          errors++;
          $display("FAIL vertical px%0d: got fs=%b v=%b f=%b d=%0d, expected fs=%b v=%b f=%b d=%0d",
                   i - 2, frame_start_out, valid, filled, disparity, e.fs, e.v, e.f, e.d);
        end
      end
    end
  endtask

  task automatic test_non_homog();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drive(1'b1, 8'd30, 1'b0, 1'b1); push(1'b1, 1'b1, 1'b0, 8'd30); end
        1: begin drive(1'b0, 8'd99, 1'b0, 1'b0); push(1'b0, 1'b0, 1'b0, 8'd0);  end
        default: begin drive(1'b0, 8'd99, 1'b1, 1'b0); push(1'b0, 1'b1, 1'b1, 8'd30); end
      endcase
      @(posedge clk); #1;
      if (sb.size() > 2) begin
        e = sb.pop_front();
        checks++;
        if ({frame_start_out, valid, filled, disparity} !== e) begin
          errors++;
          $display("FAIL non_homog px%0d: got fs=%b v=%b f=%b d=%0d, expected fs=%b v=%b f=%b d=%0d",
                   i - 2, frame_start_out, valid, filled, disparity, e.fs, e.v, e.f, e.d);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    // Run up to row 3 col 200 with a fully valid image
    for (int i = 0; i < 3 * int'(WIDTH) + 200; i++) begin
      drive(i == 0, 8'(i * 3), 1'($urandom), 1'b1);
      push(i == 0, 1'b1, 1'b0, 8'(i * 3));
      @(posedge clk); #1;
      if (sb.size() > 2) begin
        e = sb.pop_front();
        checks++;
        if ({frame_start_out, valid, filled, disparity} !== e) begin
          errors++;
          $display("FAIL pre_reset px%0d: got fs=%b v=%b f=%b d=%0d, expected fs=%b v=%b f=%b d=%0d",
                   i - 2, frame_start_out, valid, filled, disparity, e.fs, e.v, e.f, e.d);
        end
      end
    end
    rst_n = 1'b0;
    drive(1'b0, 8'd55, 1'b1, 1'b1);
    sb.delete();
    @(posedge clk); #1;
    checks++;
    if ({frame_start_out, valid, filled, disparity} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset: got fs=%b v=%b f=%b d=%0d, expected all 0",
               frame_start_out, valid, filled, disparity);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
      checks++;
      if ({frame_start_out, valid, filled, disparity} !== 11'd0) begin
        errors++;
        $display("FAIL after_reset cyc%0d: got fs=%b v=%b f=%b d=%0d, expected all 0",
                 i, frame_start_out, valid, filled, disparity);
      end
    end
    // New frame: col 0 hole must not pick up the stale line memory
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin drive(1'b1, 8'd77, 1'b1, 1'b0); push(1'b1, 1'b0, 1'b0, 8'd0); end
        1: begin drive(1'b0, 8'd5, 1'b0, 1'b1);  push(1'b0, 1'b1, 1'b0, 8'd5); end
        2: begin drive(1'b0, 8'd77, 1'b1, 1'b0); push(1'b0, 1'b1, 1'b1, 8'd5); end
        default: begin drive(1'b0, 8'd9, 1'b0, 1'b1); push(1'b0, 1'b1, 1'b0, 8'd9); end
      endcase
      @(posedge clk); #1;
      if (sb.size() > 2) begin
        e = sb.pop_front();
        checks++;
        if ({frame_start_out, valid, filled, disparity} !== e) begin
          errors++;
          $display("FAIL new_frame px%0d: got fs=%b v=%b f=%b d=%0d, expected fs=%b v=%b f=%b d=%0d",
                   i - 2, frame_start_out, valid, filled, disparity, e.fs, e.v, e.f, e.d);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    test_reset();
    test_pass_through();
    test_left_fill();
    test_vertical();
    test_non_homog();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
